// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t     : sequencer states (RUN, MEM_WAIT, DRAIN, HALT)
//   fwd_t       : ID operand source select codes
//   sb_entry_t  : one in-flight destination record {rd, wr, load}
//   sb_hit      : true when an in-flight entry produces register rs
//   fwd_pick    : forwarding priority EX > MEM > WB for one operand
package pipe_hazard_ctrl_pkg;

  localparam int RA_W      = 5;
  localparam int CNT_W     = 32;
  localparam int DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{rd: '0, wr: 1'b0, load: 1'b0};

  // x0 is hard-wired zero, so it never produces a value worth waiting for.
  function automatic logic sb_hit(input sb_entry_t e, input logic [RA_W-1:0] rs);
    return e.wr && (e.rd != '0) && (e.rd == rs);
  endfunction

  // A load in EX has no data yet; it is skipped here and handled as load-use.
  function automatic fwd_t fwd_pick(input logic used, input logic [RA_W-1:0] rs,
                                    input sb_entry_t ex, input sb_entry_t mem,
                                    input sb_entry_t wb);
    fwd_t sel;
    sel = FWD_RF;
    if (used) begin
      if (!ex.load && sb_hit(ex, rs)) sel = FWD_EX;
      else if (sb_hit(mem, rs))       sel = FWD_MEM;
      else if (sb_hit(wb, rs))        sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline datapath (drives ID decode info, ex_redirect, dmem status)
//   slave  : hazard controller (drives stage enables/flushes, forward selects)
// Handshake: a data-memory access is outstanding while dmem_req is high; it
// completes in the cycle where dmem_req and dmem_ready are both high. Any
// cycle with dmem_req high and dmem_ready low freezes the front of the pipe.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [RA_W-1:0] id_rd;
  logic            id_reg_write;
  logic            id_is_load;
  logic            id_ebreak;
  logic            ex_redirect;
  logic            dmem_req;
  logic            dmem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  state_t           dbg_state;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, id_ebreak, ex_redirect, dmem_req, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_wb_flush, fwd_a_sel, fwd_b_sel, halted, stall_cnt, dbg_state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
           id_reg_write, id_is_load, id_ebreak, ex_redirect, dmem_req, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_en, mem_wb_flush, fwd_a_sel, fwd_b_sel, halted, stall_cnt, dbg_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// In-flight destination tracker for EX/MEM/WB plus ID operand forwarding.
//   clk, rst_n            : clock, async active-low reset (clears to bubbles)
//   id_*                  : decode info of the ID instruction
//   id_ex_en/id_ex_flush  : ID/EX register control (flush loads a bubble)
//   ex_mem_en             : EX/MEM register enable
//   mem_wb_en/mem_wb_flush: MEM/WB register control
//   fwd_a_sel/fwd_b_sel   : operand source selects
//   load_use              : EX holds a load whose rd a used ID source needs
module pipe_hazard_ctrl_hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            id_ex_en,
  input  logic            id_ex_flush,
  input  logic            ex_mem_en,
  input  logic            mem_wb_en,
  input  logic            mem_wb_flush,
  output fwd_t            fwd_a_sel,
  output fwd_t            fwd_b_sel,
  output logic            load_use
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t id_entry;

  // An empty ID slot must not look like a writer downstream.
  assign id_entry = '{rd: id_rd, wr: id_valid && id_reg_write, load: id_valid && id_is_load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else begin
      if (id_ex_en)  ex_q  <= id_ex_flush ? SB_BUBBLE : id_entry;
      if (ex_mem_en) mem_q <= ex_q;
      if (mem_wb_en) wb_q  <= mem_wb_flush ? SB_BUBBLE : mem_q;
    end
  end

  assign fwd_a_sel = fwd_pick(id_rs1_used, id_rs1, ex_q, mem_q, wb_q);
  assign fwd_b_sel = fwd_pick(id_rs2_used, id_rs2, ex_q, mem_q, wb_q);

  assign load_use = id_valid && ex_q.load &&
                    ((id_rs1_used && sb_hit(ex_q, id_rs1)) ||
                     (id_rs2_used && sb_hit(ex_q, id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage IF/ID/EX/MEM/WB pipeline.
//   sys_clk : clock
//   sys_rst : asynchronous active-low reset
//   bus     : pipe_hazard_ctrl_if.slave (decode info in; enables, flushes,
//             forward selects, halted, stall_cnt, dbg_state out)
// Resolution order: HALT > DRAIN > dmem wait > redirect > load-use > ebreak.
// All stage controls are combinational from state and inputs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_stall, load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, mem_wb_flush;
  fwd_t fwd_a_sel, fwd_b_sel;

  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  pipe_hazard_ctrl_hazard_scoreboard u_sb (
    .clk          (sys_clk),
    .rst_n        (sys_rst),
    .id_valid     (bus.id_valid),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .id_rs1_used  (bus.id_rs1_used),
    .id_rs2_used  (bus.id_rs2_used),
    .id_rd        (bus.id_rd),
    .id_reg_write (bus.id_reg_write),
    .id_is_load   (bus.id_is_load),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .mem_wb_flush (mem_wb_flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .load_use     (load_use)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    // While reset is held the controls show their reset values immediately,
    // even if a dmem wait is still being signalled.
    if (sys_rst) begin
      case (state_q)
        ST_HALT: begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
        ST_DRAIN: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (mem_stall) begin
            // Freeze as in a dmem wait; the drain count pauses.
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
          end else if (drain_q == DRAIN_LAST) begin
            state_d = ST_HALT;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
        default: begin
          // RUN and MEM_WAIT share logic: the dmem_ready cycle behaves as RUN,
          // so a redirect held by the frozen EX stage is acted on right then.
          if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
            state_d      = ST_MEM_WAIT;
          end else begin
            state_d = ST_RUN;
            if (bus.ex_redirect) begin
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
            end else if (load_use) begin
              pc_en       = 1'b0;
              if_id_en    = 1'b0;
              id_ex_flush = 1'b1;
            end else if (bus.id_valid && bus.id_ebreak) begin
              // The ebreak itself is replaced by a bubble on entry.
              pc_en       = 1'b0;
              if_id_flush = 1'b1;
              id_ex_flush = 1'b1;
              state_d     = ST_DRAIN;
              drain_d     = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stall_cnt_q <= '0;
    end else if (!pc_en && (state_q != ST_HALT) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.fwd_a_sel    = fwd_a_sel;
  assign bus.fwd_b_sel    = fwd_b_sel;
  assign bus.halted       = (state_q == ST_HALT);
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.dbg_state    = state_q;

endmodule
